// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types, round-count constants and byte-level helpers.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;
  localparam int unsigned BLK_W     = 128;
  localparam int unsigned NB        = BLK_W / 8;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } fsm_e;

  // Byte n of a block lives at bits [8n +: 8]; byte 0 is FIPS-197 row 0 col 0.
  function automatic int unsigned byte_lsb(input int unsigned n);
    return 8 * n;
  endfunction

  // Inverse S-box, row 0 in the most significant 128 bits.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits 8*(255-x) bits up, and 255-x is simply ~x for a byte.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};
    return INV_SBOX_TBL[pos +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Block-in / round-key / plaintext-out bundle between controller, key store and output stage.
interface aes_inv_cipher_ctrl_if #(
  parameter int unsigned RK_IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  aes_pkg::blk_t       cipher_in;
  logic [RK_IDX_W-1:0] rk_idx;
  aes_pkg::blk_t       rk_data;
  logic                out_valid;
  logic                out_ready;
  aes_pkg::blk_t       plain_out;
  logic                busy;

  modport master (
    output in_valid, cipher_in, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, plain_out, busy
  );

  modport slave (
    input  in_valid, cipher_in, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, plain_out, busy
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round; last drops InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  blk_t state,
  input  blk_t rk,
  input  logic last,
  output blk_t dout
);

  blk_t sr;
  blk_t sb_ark;
  blk_t mc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes: row r at [8r +: 8].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  aes_inv_shift_rows u_isr (
    .din  (state),
    .dout (sr)
  );

  for (genvar n = 0; n < NB; n++) begin : g_byte
    assign sb_ark[byte_lsb(n) +: 8] = inv_sbox(sr[byte_lsb(n) +: 8]) ^ rk[byte_lsb(n) +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[32*c +: 32] = inv_mix_col(sb_ark[32*c +: 32]);
  end

  assign dout = last ? sb_ark : mc;

endmodule

// File: rtl/aes_inv_shift_rows.sv
// InvShiftRows: row r of the column-major state rotates right by r columns.
module aes_inv_shift_rows
  import aes_pkg::*;
(
  input  blk_t din,
  output blk_t dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[byte_lsb(4*c + r) +: 8] = din[byte_lsb(4*((c + 4 - r) % 4) + r) +: 8];
    end
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one round per clock, round keys fetched by index.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR       = 10,
  parameter int unsigned RK_IDX_W = 4
) (
  input logic            clk,
  input logic            rst,
  aes_inv_cipher_ctrl_if.slave bus
);

  if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256) || (NR >= (1 << RK_IDX_W))) begin : g_bad_cfg
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14 and fit in RK_IDX_W bits");
  end

  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RK_PEN  = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] ONE     = RK_IDX_W'(1);

  fsm_e                fsm;
  blk_t                st;
  blk_t                plain_q;
  blk_t                rnd_out;
  logic [RK_IDX_W-1:0] cnt;
  logic [RK_IDX_W-1:0] rk_idx_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;

  aes_inv_round u_round (
    .state (st),
    .rk    (bus.rk_data),
    .last  (fsm == FINAL),
    .dout  (rnd_out)
  );

  // Handshake flags are updated on the same edges as the state transitions they mirror.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      st          <= '0;
      cnt         <= '0;
      rk_idx_q    <= '0;
      plain_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            st         <= bus.cipher_in;
            rk_idx_q   <= RK_LAST;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm        <= INIT;
          end
        end
        INIT: begin
          st       <= st ^ bus.rk_data;
          rk_idx_q <= RK_PEN;
          cnt      <= RK_PEN;
          fsm      <= ROUND;
        end
        ROUND: begin
          st <= rnd_out;
          if (cnt == ONE) begin
            rk_idx_q <= '0;
            cnt      <= '0;
            fsm      <= FINAL;
          end else begin
            rk_idx_q <= rk_idx_q - ONE;
            cnt      <= cnt - ONE;
          end
        end
        FINAL: begin
          plain_q     <= rnd_out;
          out_valid_q <= 1'b1;
          fsm         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fsm         <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plain_out = plain_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS-197 C.1/C.3 vectors, backpressure, back-to-back, reset.
module tb_aes_inv_cipher_ctrl;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic         sel14;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] cipher_in;
  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [7:0]   fsb  [256];

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] sb_q[$];

  aes_inv_cipher_ctrl_if #(.RK_IDX_W(4)) bus10 ();
  aes_inv_cipher_ctrl_if #(.RK_IDX_W(4)) bus14 ();

  aes_inv_cipher_ctrl #(.NR(10), .RK_IDX_W(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  aes_inv_cipher_ctrl #(.NR(14), .RK_IDX_W(4)) dut14 (.clk(clk), .rst(rst), .bus(bus14));

  // Key store models: combinational lookup by the index each controller presents.
  assign bus10.in_valid  = in_valid & ~sel14;
  assign bus14.in_valid  = in_valid & sel14;
  assign bus10.cipher_in = cipher_in;
  assign bus14.cipher_in = cipher_in;
  assign bus10.out_ready = out_ready;
  assign bus14.out_ready = out_ready;
  assign bus10.rk_data   = rk10[bus10.rk_idx];
  assign bus14.rk_data   = rk14[bus14.rk_idx];

  logic         o_in_ready, o_out_valid, o_busy;
  logic [3:0]   o_rk_idx;
  logic [127:0] o_plain;
  assign o_in_ready  = sel14 ? bus14.in_ready  : bus10.in_ready;
  assign o_out_valid = sel14 ? bus14.out_valid : bus10.out_valid;
  assign o_busy      = sel14 ? bus14.busy      : bus10.busy;
  assign o_rk_idx    = sel14 ? bus14.rk_idx    : bus10.rk_idx;
  assign o_plain     = sel14 ? bus14.plain_out : bus10.plain_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: GF(2^8) inverse then the affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    if (x == 8'h00) b = 8'h00;
    else for (int i = 0; i < 254; i++) b = gm(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
  endfunction

  // Key bytes are 00,01,02,... as in FIPS-197 appendix C.
  task automatic expand(input int nk, output logic [127:0] rks [16]);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rks[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          rks[r][8*(4*c+row) +: 8] = w[4*r+c][8*(3-row) +: 8];
  endtask

  task automatic rnd_cipher();
    cipher_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Offer one block at a negedge in IDLE, follow rk_idx, check latency, result and handshake.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int nr,
                           input int bp, input string tag);
    int lat;
    bit seen;
    logic [127:0] exp_pt;
    chk({tag, " in_ready before accept"}, 128'(o_in_ready), 128'(1));
    in_valid  = 1'b1;
    cipher_in = ct;
    sb_q.push_back(pt);
    @(negedge clk);
    in_valid = 1'b0;
    rnd_cipher();
    chk({tag, " busy after accept"}, 128'(o_busy), 128'(1));
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (o_out_valid) begin
        seen = 1'b1;
      end else begin
        if (lat <= nr + 1) chk({tag, " rk_idx"}, 128'(o_rk_idx), 128'(nr - lat + 1));
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, " latency"}, 128'(seen ? lat : -1), 128'(nr + 2));
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 128'(1), 128'(0));
      exp_pt = '0;
    end else begin
      exp_pt = sb_q.pop_front();
    end
    chk({tag, " plain_out"}, o_plain, exp_pt);
    for (int i = 0; i < bp; i++) begin
      chk({tag, " hold out_valid"}, 128'(o_out_valid), 128'(1));
      chk({tag, " hold plain_out"}, o_plain, exp_pt);
      chk({tag, " hold in_ready"}, 128'(o_in_ready), 128'(0));
      in_valid = (i % 3 == 1);
      rnd_cipher();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid after handshake"}, 128'(o_out_valid), 128'(0));
    chk({tag, " in_ready after handshake"}, 128'(o_in_ready), 128'(1));
    chk({tag, " busy after handshake"}, 128'(o_busy), 128'(0));
    chk({tag, " plain_out held"}, o_plain, exp_pt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c1_ct, c3_ct, pt;
    int acc_cyc [2];
    int n_acc, n_out, cyc;
    bit found, ov_seen;
    logic [127:0] e;

    rst = 1'b1; sel14 = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cipher_in = '0;
    c1_ct = brev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c3_ct = brev(128'h8ea2b7ca516745bfeafc49904b496089);
    pt    = brev(128'h00112233445566778899aabbccddeeff);
    for (int i = 0; i < 256; i++) fsb[i] = fwd_sbox(8'(i));
    expand(4, rk10);
    expand(8, rk14);

    // Reset values.
    @(negedge clk); @(negedge clk);
    chk("reset in_ready", 128'(o_in_ready), 128'(1));
    chk("reset busy", 128'(o_busy), 128'(0));
    chk("reset out_valid", 128'(o_out_valid), 128'(0));
    chk("reset rk_idx", 128'(o_rk_idx), 128'(0));
    chk("reset plain_out", o_plain, 128'(0));
    rst = 1'b0;

    // Idle stability: {busy, rk_idx, out_valid, in_ready}.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle flags", 128'({o_busy, o_rk_idx, o_out_valid, o_in_ready}), 128'({1'b0, 4'd0, 1'b0, 1'b1}));
    end

    run_block(c1_ct, pt, 10, 0, "c1");

    out_ready = 1'b0;
    run_block(c1_ct, pt, 10, 20, "c1 backpressure");

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1; in_valid = 1'b1; cipher_in = c1_ct;
    n_acc = 0; n_out = 0; cyc = 0;
    while ((n_acc < 2 || n_out < 2) && cyc < 100) begin
      if (in_valid && o_in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        sb_q.push_back(pt);
      end
      if (o_out_valid) begin
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk("b2b plain_out", o_plain, e);
        n_out++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("b2b outputs", 128'(n_out), 128'(2));
    chk("b2b accept spacing", 128'((n_acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1), 128'(13));

    // Asynchronous reset in the middle of ROUND.
    in_valid = 1'b1; cipher_in = c1_ct;
    sb_q.push_back(pt);
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (o_rk_idx == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("midop reached rk_idx 5", 128'(found), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midop reset in_ready", 128'(o_in_ready), 128'(1));
    chk("midop reset busy", 128'(o_busy), 128'(0));
    chk("midop reset rk_idx", 128'(o_rk_idx), 128'(0));
    chk("midop reset out_valid", 128'(o_out_valid), 128'(0));
    chk("midop reset plain_out", o_plain, 128'(0));
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_out_valid) ov_seen = 1'b1;
    end
    chk("midop no out_valid", 128'(ov_seen), 128'(0));
    run_block(c1_ct, pt, 10, 0, "c1 after reset");

    // AES-256 on the NR=14 instance.
    sel14 = 1'b1;
    @(negedge clk);
    run_block(c3_ct, pt, 14, 0, "c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
Iterative AES inverse-cipher controller. It accepts one 128-bit ciphertext block, fetches round keys from an external key store, and sequences the inverse round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) at one round per clock. It returns the plaintext block over a valid/ready handshake. It sits between the key-expansion store and the decrypt output stage.

Parameters:
NR, 10, number of rounds; legal values are 10, 12 and 14; any other value is an elaboration error.
RK_IDX_W, 4, width of the round-key index.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ciphertext block offered
in_ready  out  1  controller can accept a block
cipher_in  in  128  ciphertext; byte n = bits [8n+:8]; byte 0 = first FIPS-197 byte (column-major, row 0 col 0)
rk_idx  out  RK_IDX_W  round-key index presented to the key store
rk_data  in  128  round key for rk_idx; combinational from the store, valid in the same cycle; same byte order as cipher_in
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
plain_out  out  128  plaintext result; same byte order
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: FSM goes to IDLE; state register = 0; round counter = 0; rk_idx = 0; plain_out = 0; out_valid = 0; busy = 0; in_ready = 1. Reset mid-operation discards the block; no partial output is produced.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE. All outputs decode from registered state/regs, so there is no comb path from in_valid or out_ready to any output.
- IDLE: in_ready = 1. On in_valid & in_ready: state <= cipher_in; rk_idx <= NR; go to INIT. If in_valid is low, stay in IDLE.
- INIT (1 cycle): state <= state ^ rk_data (rk_idx = NR); rk_idx <= NR-1; round counter <= NR-1; go to ROUND.
- ROUND (NR-1 cycles): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data); the counter and rk_idx decrement together. When the counter = 1 at the edge, set rk_idx <= 0 and go to FINAL.
- FINAL (1 cycle): plain_out <= InvSubBytes(InvShiftRows(state)) ^ rk_data (rk_idx = 0); out_valid <= 1; go to DONE.
- DONE: hold plain_out and out_valid stable while out_ready is low (unbounded backpressure). On out_ready: out_valid <= 0; go to IDLE. in_ready = 0 in DONE, so a new block is accepted one cycle after the output handshake at the earliest. No overlap between blocks.
- Latency: out_valid is visible in the 12th cycle after the accept edge for NR=10 (NR+2 cycles in general: INIT + NR-1 ROUND + FINAL + registration). Throughput is one block per NR+3 cycles with out_ready held high.
- rk_idx changes only on clock edges. The key store must settle rk_data within the same cycle.
- in_valid while busy is ignored; cipher_in is don't-care outside the accept cycle.
- plain_out holds its last value after the output handshake until the next FINAL.

Decomposition:
- Package aes_pkg:
  - state enum (IDLE, INIT, ROUND, FINAL, DONE)
  - NR_AES128/192/256 constants (10/12/14)
  - byte-lane index function (byte n -> bits 8n+:8)
  - inverse S-box function
- One sub-module, aes_inv_round: combinational, inputs state/rk/last.
  - last = 1: InvShiftRows -> InvSubBytes -> AddRoundKey.
  - last = 0: the same, followed by InvMixColumns.
  - Instantiates the existing InvShiftRows block.
- The controller owns the FSM, counter, registers and handshakes.

Test Plan:
- FIPS-197 C.1, NR=10:
  - key 000102…0f expanded into the store model; cipher 69c4e0d86a7b0430d8cdb78070b4c55a (byte-reversed literal); out_ready=1.
  - Expect plain_out 00112233445566778899aabbccddeeff, out_valid high 12 cycles after accept.
  - rk_idx sequence 10,9,…,0.
- FIPS-197 C.3, NR=14:
  - key 00…1f; cipher 8ea2b7ca516745bfeafc49904b496089.
  - Expect plaintext 00112233…eeff; latency 16 cycles.
- Backpressure: hold out_ready low 20 cycles after out_valid.
  - plain_out and out_valid stay stable; in_ready stays 0; in_valid pulses are ignored.
  - Release out_ready: handshake completes, in_ready returns to 1 next cycle.
- Back-to-back: two C.1 blocks with in_valid and out_ready held high.
  - Both outputs are correct; accepts are NR+3 = 13 cycles apart.
- Reset mid-op: assert rst asynchronously during ROUND (rk_idx=5).
  - Outputs go to reset values immediately (without waiting for a clock edge); no out_valid is produced.
  - A following C.1 block decrypts correctly.
- Idle stability: in_valid low for 50 cycles.
  - busy=0, rk_idx=0, out_valid=0, in_ready=1 throughout.
